// File: rtl/cpu_loader_ctrl.sv
// Host-link loader/sequencer for the CPU core: decodes command bytes, loads
// little-endian words into instruction memory and gates core reset/enable.
module cpu_loader_ctrl #(
    parameter int unsigned NB_DATA         = 32,
    parameter int unsigned IMEM_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       i_rst_n,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    input  logic                       i_cpu_halt,
    output logic [NB_DATA-1:0]         o_imem_data,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic                       o_imem_wen,
    output logic [1:0]                 o_mem_wsize,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    output logic                       o_load_done,
    output logic                       o_err,
    output logic [2:0]                 o_state
);

    localparam int unsigned CW    = IMEM_ADDR_WIDTH + 1;
    localparam int unsigned Depth = 1 << IMEM_ADDR_WIDTH;

    localparam logic [7:0] CmdLoad = 8'h4C;
    localparam logic [7:0] CmdRun  = 8'h52;
    localparam logic [7:0] CmdStep = 8'h53;
    localparam logic [7:0] CmdHalt = 8'h48;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLdCnt  = 3'd1,
        StLdData = 3'd2,
        StRun    = 3'd3,
        StStep   = 3'd4
    } state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                word_cnt_q, word_cnt_d;
    logic [CW-1:0]                addr_q, addr_d;
    logic [1:0]                   byte_cnt_q, byte_cnt_d;
    logic [NB_DATA-1:0]           shift_q, shift_d;
    logic [NB_DATA-1:0]           data_q, data_d;
    logic [IMEM_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                         wen_q, wen_d;
    logic                         cpu_en_q, cpu_en_d;
    logic                         cpu_rst_q, cpu_rst_d;
    logic                         load_done_q, load_done_d;
    logic                         err_q, err_d;
    logic                         finish_q, finish_d;
    logic                         ready;

    // finish_q delays release of core reset by one cycle past the last write
    // strobe; the program counts as resident for R/S from that cycle on.
    assign ready = load_done_q | finish_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        addr_d      = addr_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        waddr_d     = waddr_q;
        wen_d       = 1'b0;
        cpu_en_d    = 1'b0;
        cpu_rst_d   = cpu_rst_q;
        load_done_d = load_done_q;
        err_d       = 1'b0;
        finish_d    = 1'b0;

        if (finish_q) begin
            cpu_rst_d   = 1'b0;
            load_done_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CmdLoad: begin
                            state_d     = StLdCnt;
                            load_done_d = 1'b0;
                            cpu_rst_d   = 1'b1;
                        end
                        CmdRun: begin
                            if (ready) begin
                                state_d  = StRun;
                                cpu_en_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        CmdStep: begin
                            if (ready) begin
                                state_d  = StStep;
                                cpu_en_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            StLdCnt: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0 || 32'(i_rx_data) > Depth) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        word_cnt_d = CW'(i_rx_data);
                        addr_d     = '0;
                        byte_cnt_d = '0;
                        state_d    = StLdData;
                    end
                end
            end
            StLdData: begin
                if (i_rx_valid) begin
                    shift_d    = {i_rx_data, shift_q[NB_DATA-1:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        data_d  = shift_d;
                        waddr_d = addr_q[IMEM_ADDR_WIDTH-1:0];
                        wen_d   = 1'b1;
                        addr_d  = addr_q + CW'(1);
                        if (addr_d == word_cnt_q) begin
                            state_d  = StIdle;
                            finish_d = 1'b1;
                        end
                    end
                end
            end
            StRun: begin
                if (i_cpu_halt || (i_rx_valid && i_rx_data == CmdHalt)) begin
                    state_d = StIdle;
                end else begin
                    cpu_en_d = 1'b1;
                end
            end
            StStep: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            addr_q      <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            waddr_q     <= '0;
            wen_q       <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b1;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            finish_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            addr_q      <= addr_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            waddr_q     <= waddr_d;
            wen_q       <= wen_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
            finish_q    <= finish_d;
        end
    end

    assign o_imem_data  = data_q;
    assign o_imem_waddr = waddr_q;
    assign o_imem_wen   = wen_q;
    assign o_mem_wsize  = 2'b10;
    assign o_cpu_en     = cpu_en_q;
    assign o_cpu_rst    = cpu_rst_q;
    assign o_load_done  = load_done_q;
    assign o_err        = err_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_cpu_loader_ctrl.sv
// Self-checking bench for cpu_loader_ctrl: randomized loads and run/step
// sequences checked against expectations built from the command protocol.
module tb_cpu_loader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        cpu_halt = 1'b0;
    logic [31:0] imem_data;
    logic [4:0]  imem_waddr;
    logic        imem_wen;
    logic [1:0]  mem_wsize;
    logic        cpu_en;
    logic        cpu_rst;
    logic        load_done;
    logic        err;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_fail = 0;

    cpu_loader_ctrl #(
        .NB_DATA        (32),
        .IMEM_ADDR_WIDTH(5)
    ) dut (
        .clk         (clk),
        .i_rst_n     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_cpu_halt  (cpu_halt),
        .o_imem_data (imem_data),
        .o_imem_waddr(imem_waddr),
        .o_imem_wen  (imem_wen),
        .o_mem_wsize (mem_wsize),
        .o_cpu_en    (cpu_en),
        .o_cpu_rst   (cpu_rst),
        .o_load_done (load_done),
        .o_err       (err),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    // Observed write strobes, error pulses and enabled cycles.
    logic [4:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          err_cnt = 0;
    int          en_cnt = 0;
    int          cyc = 0;
    int          last_wen_cyc = -1;
    int          rst_fall_cyc = -1;
    logic        prev_rst = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (imem_wen === 1'b1) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_data);
            last_wen_cyc = cyc;
        end
        if (err === 1'b1) err_cnt++;
        if (cpu_en === 1'b1) en_cnt++;
        if (prev_rst === 1'b1 && cpu_rst === 1'b0) rst_fall_cyc = cyc;
        prev_rst = cpu_rst;
    end

    logic [31:0] exp_words[64];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({state, cpu_rst, cpu_en, load_done, err, imem_wen, imem_waddr, imem_data, mem_wsize}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL %s: state=%0d rst=%b en=%b done=%b err=%b wen=%b addr=%0d data=%h ws=%b",
                     tag, state, cpu_rst, cpu_en, load_done, err, imem_wen, imem_waddr,
                     imem_data, mem_wsize);
        end
    endtask

    // Loads exp_words[0..n-1]; expects exactly those writes at addresses 0..n-1.
    task automatic load_prog(input int n, input bit gaps);
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h4C);
        n_cmp++;
        if (cpu_rst !== 1'b1 || load_done !== 1'b0 || state !== 3'd1) begin
            n_fail++;
            $display("FAIL load_cmd: rst=%b done=%b state=%0d, want 1 0 1", cpu_rst, load_done, state);
        end
        if (gaps) idle($urandom_range(0, 2));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (gaps) idle($urandom_range(0, 2));
                send_byte(exp_words[i][8*b +: 8]);
            end
        end
        idle(3);
        n_cmp++;
        if (wr_addr_q.size() != n) begin
            n_fail++;
            $display("FAIL load_count n=%0d: got %0d writes, want %0d", n, wr_addr_q.size(), n);
        end
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            n_cmp++;
            if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== exp_words[i]) begin
                n_fail++;
                $display("FAIL load_word %0d: addr=%0d data=%h, want addr=%0d data=%h",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_words[i]);
            end
        end
        n_cmp++;
        if (load_done !== 1'b1 || cpu_rst !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL load_end: done=%b rst=%b state=%0d, want 1 0 0", load_done, cpu_rst, state);
        end
        n_cmp++;
        if (rst_fall_cyc != last_wen_cyc + 1) begin
            n_fail++;
            $display("FAIL rst_release: fell cyc %0d, want %0d", rst_fall_cyc, last_wen_cyc + 1);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_values("reset");
    endtask

    task automatic test_no_load_errors();
        int e0;
        int en0;
        logic [7:0] cmds[3];
        cmds[0] = 8'h53;
        cmds[1] = 8'h52;
        cmds[2] = 8'h7A;
        for (int i = 0; i < 3; i++) begin
            e0  = err_cnt;
            en0 = en_cnt;
            send_byte(cmds[i]);
            idle(2);
            n_cmp++;
            if (err_cnt != e0 + 1 || en_cnt != en0 || state !== 3'd0) begin
                n_fail++;
                $display("FAIL no_load_cmd %h: errs=%0d en_cycles=%0d state=%0d, want 1 0 0",
                         cmds[i], err_cnt - e0, en_cnt - en0, state);
            end
        end
    endtask

    task automatic test_load_fixed(input bit gaps);
        exp_words[0] = 32'h00500013;
        exp_words[1] = 32'h00100093;
        load_prog(2, gaps);
    endtask

    task automatic test_bad_count();
        int e0;
        logic [7:0] cnts[2];
        cnts[0] = 8'h00;
        cnts[1] = 8'h21;
        for (int i = 0; i < 2; i++) begin
            e0 = err_cnt;
            send_byte(8'h4C);
            send_byte(cnts[i]);
            idle(2);
            n_cmp++;
            if (err_cnt != e0 + 1 || state !== 3'd0 || load_done !== 1'b0 || cpu_rst !== 1'b1) begin
                n_fail++;
                $display("FAIL bad_count %h: errs=%0d state=%0d done=%b rst=%b, want 1 0 0 1",
                         cnts[i], err_cnt - e0, state, load_done, cpu_rst);
            end
        end
    endtask

    task automatic test_load_random();
        int n;
        for (int t = 0; t < 4; t++) begin
            n = (t == 0) ? 32 : int'($urandom_range(1, 32));
            for (int i = 0; i < n; i++) exp_words[i] = $urandom;
            load_prog(n, t[0]);
        end
    endtask

    // mode 0: halt input, 1: 'H' byte, 2: both in the same cycle
    task automatic run_exit(input int mode);
        int e0;
        logic [7:0] b;
        e0 = err_cnt;
        send_byte(8'h52);
        n_cmp++;
        if (cpu_en !== 1'b1 || state !== 3'd3) begin
            n_fail++;
            $display("FAIL run_start mode %0d: en=%b state=%0d, want 1 3", mode, cpu_en, state);
        end
        repeat ($urandom_range(2, 8)) begin
            do b = 8'($urandom); while (b == 8'h48);
            rx_data  = b;
            rx_valid = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if (cpu_en !== 1'b1 || state !== 3'd3) begin
                n_fail++;
                $display("FAIL run_hold mode %0d: en=%b state=%0d, want 1 3", mode, cpu_en, state);
            end
        end
        rx_valid = 1'b0;
        if (mode != 1) cpu_halt = 1'b1;
        if (mode != 0) begin
            rx_data  = 8'h48;
            rx_valid = 1'b1;
        end
        @(negedge clk);
        cpu_halt = 1'b0;
        rx_valid = 1'b0;
        n_cmp++;
        if (cpu_en !== 1'b0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL run_exit mode %0d: en=%b state=%0d, want 0 0", mode, cpu_en, state);
        end
        idle(2);
        n_cmp++;
        if (err_cnt != e0 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL run_no_err mode %0d: errs=%0d en=%b, want 0 0", mode, err_cnt - e0, cpu_en);
        end
    endtask

    task automatic test_run();
        exp_words[0] = $urandom;
        load_prog(1, 1'b0);
        for (int m = 0; m < 3; m++) run_exit(m);
    endtask

    task automatic test_step();
        int e0;
        int en0;
        e0  = err_cnt;
        en0 = en_cnt;
        send_byte(8'h53);
        n_cmp++;
        if (cpu_en !== 1'b1 || state !== 3'd4) begin
            n_fail++;
            $display("FAIL step_start: en=%b state=%0d, want 1 4", cpu_en, state);
        end
        cpu_halt = 1'b1;
        rx_data  = 8'h48;
        rx_valid = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        rx_valid = 1'b0;
        idle(3);
        n_cmp++;
        if (en_cnt != en0 + 1 || err_cnt != e0 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL step_once: en_cycles=%0d errs=%0d state=%0d, want 1 0 0",
                     en_cnt - en0, err_cnt - e0, state);
        end
    endtask

    task automatic test_reset_mid_load();
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h4C);
        send_byte(8'h02);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        do_reset();
        check_reset_values("mid_load_reset");
        idle(4);
        n_cmp++;
        if (wr_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL mid_load_writes: got %0d writes, want 1", wr_addr_q.size());
        end
        for (int i = 0; i < 3; i++) exp_words[i] = $urandom;
        load_prog(3, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_no_load_errors();
        test_load_fixed(1'b0);
        test_load_fixed(1'b1);
        test_bad_count();
        test_load_random();
        test_run();
        test_step();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_loader_ctrl.md
# cpu_loader_ctrl

Byte-stream controller that sequences the CPU core from a host link. It sits between the UART receiver and the CPU subsystem. It decodes single-byte commands, assembles little-endian 32-bit words and writes them into instruction memory through the core's write port. It holds the core in reset while loading, then gates the core enable for continuous run or single-step.

## Interface
Parameters:
- NB_DATA, 32, instruction word width; fixed at 4 bytes.
- IMEM_ADDR_WIDTH, 5, instruction-memory word-address width; depth = 2^IMEM_ADDR_WIDTH words.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; byte accepted on the edge where it is high.
- i_cpu_halt  in  1  core reports halt instruction retired.
- o_imem_data  out  NB_DATA  assembled word to instruction memory.
- o_imem_waddr  out  IMEM_ADDR_WIDTH  word address of write.
- o_imem_wen  out  1  one-cycle write strobe.
- o_mem_wsize  out  2  write size; constant 2'b10 (word).
- o_cpu_en  out  1  core clock-enable.
- o_cpu_rst  out  1  active-high synchronous reset to core.
- o_load_done  out  1  level; a complete program is resident.
- o_err  out  1  one-cycle protocol-error pulse.
- o_state  out  3  current FSM state, for debug.

## Operation
- States: IDLE=0, LD_CNT=1, LD_DATA=2, RUN=3, STEP=4.
- IDLE accepts command bytes:
  - 0x4C 'L' → LD_CNT. Clears o_load_done, sets o_cpu_rst.
  - 0x52 'R' → RUN.
  - 0x53 'S' → STEP.
  - Any other byte pulses o_err and stays in IDLE.
- 'R' or 'S' while o_load_done=0 pulses o_err and stays in IDLE.
- LD_CNT: the next byte is word count N.
  - N=0 or N>2^IMEM_ADDR_WIDTH: o_err pulse, → IDLE. o_cpu_rst stays high and o_load_done stays 0.
  - Otherwise latch N, clear the address and byte counters, → LD_DATA.
- LD_DATA: bytes shift in little-endian; the first byte is bits [7:0].
  - On each 4th accepted byte, write the word at the current address, then increment the address.
  - After the N-th word: → IDLE, o_load_done=1, o_cpu_rst=0.
- RUN: o_cpu_en=1 every cycle.
  - Exit to IDLE when i_cpu_halt is sampled high or byte 0x48 'H' is accepted.
  - Other bytes in RUN are ignored; no error.
- STEP: o_cpu_en=1 for exactly one cycle, then → IDLE. i_cpu_halt and received bytes are ignored.
- Simultaneous i_cpu_halt and 'H' in RUN: single exit, no o_err.
- Address counter is IMEM_ADDR_WIDTH+1 bits internally. The write address never wraps because N is range-checked.

## Timing
- Reset values:
  - state=IDLE.
  - o_imem_data=0, o_imem_waddr=0, o_imem_wen=0.
  - o_cpu_en=0, o_cpu_rst=1, o_load_done=0, o_err=0.
  - o_mem_wsize=2'b10.
- Reset mid-load discards partial words and counters, and returns to the values above.
- All outputs are registered.
- Response latency from an accepting edge (byte accepted on edge k):
  - o_imem_wen (after a 4th byte): high in cycle k+1, with o_imem_data and o_imem_waddr valid in that same cycle.
  - o_err: high in cycle k+1 only.
- o_cpu_rst:
  - Rises the cycle after 'L' is accepted.
  - Falls, and o_load_done rises, in the cycle after the last write strobe.
- RUN/STEP enable:
  - o_cpu_en is high from the cycle after 'R' or 'S' is accepted.
  - In RUN it drops in the cycle after i_cpu_halt or 'H' is sampled.
- o_state reflects the registered state.
- There is no back-pressure. One byte per cycle must be accepted in every state.

## Test plan
- Reset: hold i_rst_n=0 then release → o_cpu_rst=1, o_cpu_en=0, o_load_done=0, o_state=0.
- Load: bytes 4C,02, 13,00,50,00, 93,00,10,00 (back-to-back and with gaps) →
  - Two o_imem_wen pulses: addr0=0x00500013, addr1=0x00100093.
  - Then o_cpu_rst=0 and o_load_done=1.
- Bad count: 4C,00 → one o_err pulse, state back to IDLE, o_load_done=0. Then 4C,21 with depth 32 → o_err pulse.
- Run after load:
  - 52 → o_cpu_en=1 continuously.
  - Pulse i_cpu_halt → o_cpu_en=0 next cycle, IDLE.
  - Repeat with 'H' as the exit.
  - Repeat with 'H' and halt in the same cycle → single exit, no o_err.
- Step: 53 after load → o_cpu_en high for exactly one cycle. 'S' before any load → o_err, o_cpu_en stays 0. Unknown byte 0x7A in IDLE → o_err.
- Reset mid-load: assert i_rst_n after 6 data bytes → no further wen. A fresh 'L' load then writes starting at addr 0.
